// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master engine and its prescaler.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL,
        DONE
    } spi_state_e;

    // Modes are encoded as {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    localparam int SPI_DATA_WIDTH_DEF = 8;
    localparam int SPI_DIV_WIDTH_DEF  = 6;

endpackage

// File: rtl/spi_prescaler.sv
// Loadable down-counter producing a one-cycle tick every (divider+1) clocks
// while enabled; the divider is captured on load and reused for every reload.
module spi_prescaler
    import spi_pkg::*;
#(
    parameter int DIV_WIDTH = SPI_DIV_WIDTH_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic                 enable_i,
    input  logic [DIV_WIDTH-1:0] divider_i,
    output logic                 tick_o
);

    logic [DIV_WIDTH-1:0] reload_q;
    logic [DIV_WIDTH-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            reload_q <= '0;
            count_q  <= '0;
        end else if (load_i) begin
            reload_q <= divider_i;
            count_q  <= divider_i;
        end else if (enable_i) begin
            if (count_q == '0) begin
                count_q <= reload_q;
            end else begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign tick_o = enable_i && (count_q == '0);

endmodule

// File: rtl/spi_master_engine.sv
// SPI master: FSM, shift registers, half-period counter, MISO synchroniser
// and chip-select decode, driven by ticks from spi_prescaler.
module spi_master_engine
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH   = SPI_DATA_WIDTH_DEF,
    parameter int DIV_WIDTH    = SPI_DIV_WIDTH_DEF,
    parameter int NUM_CS       = 4,
    parameter int CS_SEL_WIDTH = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [DATA_WIDTH-1:0]   tx_data,
    input  logic [DIV_WIDTH-1:0]    divider,
    input  logic                    cpol,
    input  logic                    cpha,
    input  logic                    lsb_first,
    input  logic [CS_SEL_WIDTH-1:0] cs_select,
    output logic [DATA_WIDTH-1:0]   rx_data,
    output logic                    busy,
    output logic                    done,
    output logic                    spi_sclk,
    output logic                    spi_mosi,
    input  logic                    spi_miso,
    output logic [NUM_CS-1:0]       spi_cs_n
);

    localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_WIDTH-1:0] LAST_HALF = CNT_WIDTH'(2 * DATA_WIDTH - 1);

    spi_state_e              state_q, state_d;
    logic [1:0]              mode_q;
    logic                    lsbFirst_q;
    logic [CS_SEL_WIDTH-1:0] csSel_q;
    logic [DATA_WIDTH-1:0]   txShift_q;
    logic [DATA_WIDTH-1:0]   rxShift_q;
    logic [DATA_WIDTH-1:0]   rxData_q;
    logic [CNT_WIDTH-1:0]    bitCnt_q;
    logic                    sclk_q, sclk_d;
    logic                    mosi_q, mosi_d;
    logic [NUM_CS-1:0]       csN_q, csN_d;
    logic                    sync1_q, sync2_q;

    logic                    tick;
    logic                    active;
    logic                    startAcc;
    logic                    abortReq;
    logic                    sampleOnLead;
    logic                    sampleOnTrail;
    logic                    sampleNow;
    logic                    shiftOutNow;
    logic [CS_SEL_WIDTH-1:0] csSelNext;

    function automatic logic headBit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shiftWord(input logic [DATA_WIDTH-1:0] w,
                                                        input logic lsb);
        return lsb ? {1'b0, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], 1'b0};
    endfunction

    spi_prescaler #(
        .DIV_WIDTH(DIV_WIDTH)
    ) uPrescaler (
        .clock    (clock),
        .reset    (reset),
        .load_i   (startAcc),
        .enable_i (active),
        .divider_i(divider),
        .tick_o   (tick)
    );

    assign active    = (state_q == LEAD) || (state_q == SHIFT) || (state_q == TRAIL);
    assign startAcc  = start && (state_q == IDLE);
    assign abortReq  = abort && active;
    assign csSelNext = startAcc ? cs_select : csSel_q;

    // Even half-periods end on a leading edge, odd ones on a trailing edge
    assign sampleOnLead  = (mode_q == SPI_MODE0) || (mode_q == SPI_MODE2);
    assign sampleOnTrail = (mode_q == SPI_MODE1) || (mode_q == SPI_MODE3);
    assign sampleNow     = (state_q == SHIFT) && tick &&
                           (bitCnt_q[0] ? sampleOnTrail : sampleOnLead);
    assign shiftOutNow   = (state_q == SHIFT) && tick &&
                           (bitCnt_q[0] ? sampleOnLead : sampleOnTrail);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LEAD;
            LEAD:    if (tick) state_d = SHIFT;
            SHIFT:   if (tick && (bitCnt_q == LAST_HALF)) state_d = TRAIL;
            TRAIL:   if (tick) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abortReq) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        busy   = active;
        done   = (state_q == DONE);
        sclk_d = mode_q[1];
        mosi_d = mosi_q;
        csN_d  = '1;
        case (state_q)
            IDLE: begin
                sclk_d = cpol;
                mosi_d = (start && !cpha) ? headBit(tx_data, lsb_first) : 1'b0;
            end
            SHIFT: begin
                sclk_d = tick ? ~sclk_q : sclk_q;
                if (shiftOutNow) begin
                    mosi_d = headBit(txShift_q, lsbFirst_q);
                end
            end
            DONE:    mosi_d = 1'b0;
            default: ;
        endcase
        if (abortReq) begin
            sclk_d = mode_q[1];
            mosi_d = 1'b0;
        end
        // Out-of-range selects leave every line high but the transfer still runs
        if ((state_d == LEAD) || (state_d == SHIFT) || (state_d == TRAIL)) begin
            for (int i = 0; i < NUM_CS; i++) begin
                if (csSelNext == CS_SEL_WIDTH'(i)) begin
                    csN_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q     <= '0;
            lsbFirst_q <= 1'b0;
            csSel_q    <= '0;
            txShift_q  <= '0;
            rxShift_q  <= '0;
            rxData_q   <= '0;
            bitCnt_q   <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            csN_q      <= '1;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
        end else begin
            sync1_q <= spi_miso;
            sync2_q <= sync1_q;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            csN_q   <= csN_d;
            if (startAcc) begin
                mode_q     <= {cpol, cpha};
                lsbFirst_q <= lsb_first;
                csSel_q    <= cs_select;
                txShift_q  <= cpha ? tx_data : shiftWord(tx_data, lsb_first);
                rxShift_q  <= '0;
                bitCnt_q   <= '0;
            end else begin
                if (shiftOutNow) begin
                    txShift_q <= shiftWord(txShift_q, lsbFirst_q);
                end
                if (sampleNow) begin
                    rxShift_q <= lsbFirst_q ? {sync2_q, rxShift_q[DATA_WIDTH-1:1]}
                                            : {rxShift_q[DATA_WIDTH-2:0], sync2_q};
                end
                if ((state_q == SHIFT) && tick) begin
                    bitCnt_q <= bitCnt_q + 1'b1;
                end
                if ((state_q == TRAIL) && tick && !abortReq) begin
                    rxData_q <= rxShift_q;
                end
            end
        end
    end

    assign rx_data  = rxData_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = csN_q;

endmodule

// File: tb/tb_spi_master_engine.sv
// Directed self-checking bench for spi_master_engine with default parameters
// (8-bit words, 6-bit divider, four chip selects).
module tb_spi_master_engine;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] tx_data;
    logic [5:0] divider;
    logic       cpol;
    logic       cpha;
    logic       lsb_first;
    logic [2:0] cs_select;
    logic [7:0] rx_data;
    logic       busy;
    logic       done;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;
    logic [3:0] spi_cs_n;

    int checkCount = 0;
    int failCount  = 0;

    int         busyCycles;
    int         doneCount;
    int         mosiCount;
    int         csBad;
    logic [7:0] mosiStream;
    logic       firstMosi;
    logic [3:0] csFirst;
    int         lateDone;

    spi_master_engine dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .tx_data  (tx_data),
        .divider  (divider),
        .cpol     (cpol),
        .cpha     (cpha),
        .lsb_first(lsb_first),
        .cs_select(cs_select),
        .rx_data  (rx_data),
        .busy     (busy),
        .done     (done),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_cs_n (spi_cs_n)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Runs one transfer for a fixed cycle budget. With usePat, MISO carries
    // misoPat (first bit in [7]) two cycles ahead of each divider=0 sample point.
    task automatic applyStimulus(input logic [7:0] txV, input logic [5:0] divV,
                                 input logic cpolV, input logic cphaV, input logic lsbV,
                                 input logic [2:0] csV, input logic [3:0] expCs,
                                 input logic [7:0] misoPat, input logic usePat,
                                 input int restartAt);
        int   budget;
        logic prevSclk;
        budget = (int'(divV) + 1) * 18 + 8;
        @(negedge clock);
        tx_data   = txV;
        divider   = divV;
        cpol      = cpolV;
        cpha      = cphaV;
        lsb_first = lsbV;
        cs_select = csV;
        start     = 1'b1;
        if (usePat) spi_miso = misoPat[7];
        prevSclk   = spi_sclk;
        busyCycles = 0;
        doneCount  = 0;
        mosiCount  = 0;
        mosiStream = 8'h00;
        csBad      = 0;
        csFirst    = 4'hF;
        firstMosi  = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clock);
            start = 1'b0;
            if (c == restartAt) begin
                start     = 1'b1;
                tx_data   = 8'h55;
                cs_select = 3'd0;
            end
            if (usePat) spi_miso = (c < 16) ? misoPat[7 - c / 2] : 1'b0;
            if (busy) begin
                busyCycles++;
                if (busyCycles == 1) begin
                    csFirst   = spi_cs_n;
                    firstMosi = spi_mosi;
                end
                if (spi_cs_n !== expCs) csBad++;
            end
            if (done) doneCount++;
            if ((spi_sclk !== prevSclk) && ((spi_sclk != cpolV) == !cphaV)) begin
                mosiStream = {mosiStream[6:0], spi_mosi};
                mosiCount++;
            end
            prevSclk = spi_sclk;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        cpol      = 1'b0;
        cpha      = 1'b0;
        lsb_first = 1'b0;
        spi_miso  = 1'b0;
        tx_data   = 8'h00;
        divider   = 6'd0;
        cs_select = 3'd0;
        repeat (3) @(negedge clock);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_sclk", spi_sclk, 0);
        checkOutput("rst_mosi", spi_mosi, 0);
        checkOutput("rst_cs", spi_cs_n, 4'hF);
        checkOutput("rst_rx", rx_data, 8'h00);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        $display("[TB] mode 0 loopback, divider 0");
        applyStimulus(8'hA5, 6'd0, 1'b0, 1'b0, 1'b0, 3'd0, 4'b1110, 8'hA5, 1'b1, -1);
        checkOutput("m0_rx", rx_data, 8'hA5);
        checkOutput("m0_busy_len", busyCycles, 18);
        checkOutput("m0_done", doneCount, 1);
        checkOutput("m0_cs_active", csFirst, 4'b1110);
        checkOutput("m0_cs_steady", csBad, 0);
        checkOutput("m0_mosi", mosiStream, 8'hA5);
        checkOutput("m0_sclk_idle", spi_sclk, 0);

        $display("[TB] mode 3, divider 3, miso high");
        cpol     = 1'b1;
        cpha     = 1'b1;
        spi_miso = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("m3_sclk_before", spi_sclk, 1);
        applyStimulus(8'h3C, 6'd3, 1'b1, 1'b1, 1'b0, 3'd0, 4'b1110, 8'h00, 1'b0, -1);
        checkOutput("m3_rx", rx_data, 8'hFF);
        checkOutput("m3_busy_len", busyCycles, 72);
        checkOutput("m3_done", doneCount, 1);
        checkOutput("m3_mosi", mosiStream, 8'h3C);
        checkOutput("m3_mosi_bits", mosiCount, 8);
        checkOutput("m3_sclk_after", spi_sclk, 1);

        $display("[TB] mode 0, lsb first");
        cpol = 1'b0;
        cpha = 1'b0;
        repeat (3) @(negedge clock);
        applyStimulus(8'h01, 6'd0, 1'b0, 1'b0, 1'b1, 3'd0, 4'b1110, 8'b1000_0000, 1'b1, -1);
        checkOutput("lsb_first_mosi", firstMosi, 1);
        checkOutput("lsb_rx", rx_data, 8'h01);
        checkOutput("lsb_done", doneCount, 1);
        checkOutput("lsb_mosi_order", mosiStream, 8'h80);

        $display("[TB] abort mid transfer");
        @(negedge clock);
        tx_data   = 8'hFF;
        divider   = 6'd0;
        cs_select = 3'd0;
        lsb_first = 1'b0;
        spi_miso  = 1'b1;
        start     = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clock);
            start = 1'b0;
        end
        checkOutput("abort_busy_before", busy, 1);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_cs", spi_cs_n, 4'hF);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_sclk", spi_sclk, 0);
        checkOutput("abort_mosi", spi_mosi, 0);
        checkOutput("abort_rx_kept", rx_data, 8'h01);
        lateDone = 0;
        repeat (20) begin
            @(negedge clock);
            if (done) lateDone++;
        end
        checkOutput("abort_no_done", lateDone, 0);

        $display("[TB] restart while busy, out-of-range select");
        applyStimulus(8'hC3, 6'd0, 1'b0, 1'b0, 1'b0, 3'd5, 4'b1111, 8'h00, 1'b0, 5);
        checkOutput("restart_rx", rx_data, 8'hFF);
        checkOutput("restart_done", doneCount, 1);
        checkOutput("restart_busy_len", busyCycles, 18);
        checkOutput("restart_cs_high", csBad, 0);
        checkOutput("restart_mosi", mosiStream, 8'hC3);

        $display("[TB] reset mid transfer");
        @(negedge clock);
        tx_data   = 8'h5A;
        cs_select = 3'd1;
        start     = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            start = 1'b0;
        end
        checkOutput("midrst_busy_before", busy, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_sclk", spi_sclk, 0);
        checkOutput("midrst_mosi", spi_mosi, 0);
        checkOutput("midrst_cs", spi_cs_n, 4'hF);
        checkOutput("midrst_rx", rx_data, 8'h00);
        applyStimulus(8'h96, 6'd0, 1'b0, 1'b0, 1'b0, 3'd2, 4'b1011, 8'h96, 1'b1, -1);
        checkOutput("postrst_busy_len", busyCycles, 18);
        checkOutput("postrst_done", doneCount, 1);
        checkOutput("postrst_rx", rx_data, 8'h96);
        checkOutput("postrst_cs", csFirst, 4'b1011);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
